// File: rtl/dsp_mux_pkg.sv
// Shared constants and helpers for the DSP48A1-style datapath muxes.
package dsp_mux_pkg;

  localparam int unsigned PIPE_MUX_MAX_DEPTH  = 4;
  localparam int unsigned PIPE_MUX_MAX_INPUTS = 8;

  // Select width for an n-input mux; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_mux_reg.sv
// One {data, valid} pipeline stage with clock enable and async active-low reset.
module pipe_reg #(
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (ce_i) begin
      data_q  <= data_i;
      valid_q <= valid_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_mux.sv
// N-input datapath mux with optional registered select, DEPTH-stage output
// pipeline and a sticky out-of-range-select error flag.
module pipe_mux
  import dsp_mux_pkg::*;
#(
  parameter  int unsigned WIDTH      = 18,
  parameter  int unsigned NUM_INPUTS = 4,
  parameter  int unsigned SELREG     = 1,
  parameter  int unsigned DEPTH      = 1,
  localparam int unsigned SW         = sel_width(NUM_INPUTS)
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        CE,
  input  logic [NUM_INPUTS*WIDTH-1:0] data_in,
  input  logic [SW-1:0]               sel,
  input  logic                        sel_ce,
  input  logic                        in_valid,
  input  logic                        err_clr,
  output logic [WIDTH-1:0]            data_out,
  output logic                        out_valid,
  output logic                        sel_err
);

  if (DEPTH > PIPE_MUX_MAX_DEPTH || NUM_INPUTS < 2 ||
      NUM_INPUTS > PIPE_MUX_MAX_INPUTS || WIDTH < 1 || WIDTH > 48) begin : g_bad_params
    $error("pipe_mux: illegal parameters WIDTH=%0d NUM_INPUTS=%0d DEPTH=%0d",
           WIDTH, NUM_INPUTS, DEPTH);
  end

  logic [SW-1:0]    sel_q;
  logic             sel_vld;
  logic [WIDTH-1:0] mux_out;

  // The select register is an ordinary pipe stage whose valid bit is unused.
  if (SELREG != 0) begin : g_sel_reg
    pipe_reg #(.WIDTH(SW)) u_sel_reg (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .ce_i   (CE & sel_ce),
      .data_i (sel),
      .valid_i(1'b0),
      .data_o (sel_q),
      .valid_o(sel_vld)
    );
  end else begin : g_sel_comb
    assign sel_q   = sel;
    assign sel_vld = 1'b0;
  end

  always_comb begin
    mux_out = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (sel_q == SW'(i)) mux_out = data_in[i*WIDTH +: WIDTH];
    end
  end

  logic [WIDTH-1:0] stg_data [DEPTH+1];
  logic [DEPTH:0]   stg_vld;

  assign stg_data[0] = mux_out;
  assign stg_vld[0]  = in_valid;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_reg #(.WIDTH(WIDTH)) u_stage (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .ce_i   (CE),
      .data_i (stg_data[k]),
      .valid_i(stg_vld[k]),
      .data_o (stg_data[k+1]),
      .valid_o(stg_vld[k+1])
    );
  end

  assign data_out  = stg_data[DEPTH];
  assign out_valid = stg_vld[DEPTH];

  // A power-of-two input count makes every select value legal.
  if ((NUM_INPUTS & (NUM_INPUTS - 1)) == 0) begin : g_no_err
    assign sel_err = 1'b0;
  end else begin : g_err
    logic sel_oor;
    logic sel_err_d;
    logic sel_err_q;

    assign sel_oor = (32'(sel_q) >= NUM_INPUTS);

    always_comb begin
      sel_err_d = sel_err_q;
      if (CE && in_valid && sel_oor) sel_err_d = 1'b1;
      else if (err_clr)              sel_err_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) sel_err_q <= 1'b0;
      else        sel_err_q <= sel_err_d;
    end

    assign sel_err = sel_err_q;
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, CLK, RST_N, CE, sel_ce, err_clr, sel_vld};

endmodule

// File: tb/tb_pipe_mux.sv
// Directed bench for pipe_mux: a registered 3-input DEPTH=2 instance and a
// combinational 4-input DEPTH=0 instance.
module tb_pipe_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instance A: WIDTH=8, NUM_INPUTS=3, SELREG=1, DEPTH=2
  logic        rst_n;
  logic        a_ce, a_sel_ce, a_in_valid, a_err_clr;
  logic [23:0] a_data_in;
  logic [1:0]  a_sel;
  logic [7:0]  a_data_out;
  logic        a_out_valid, a_sel_err;

  pipe_mux #(.WIDTH(8), .NUM_INPUTS(3), .SELREG(1), .DEPTH(2)) u_dut_a (
    .CLK      (clk),
    .RST_N    (rst_n),
    .CE       (a_ce),
    .data_in  (a_data_in),
    .sel      (a_sel),
    .sel_ce   (a_sel_ce),
    .in_valid (a_in_valid),
    .err_clr  (a_err_clr),
    .data_out (a_data_out),
    .out_valid(a_out_valid),
    .sel_err  (a_sel_err)
  );

  // Instance B: WIDTH=18, NUM_INPUTS=4, SELREG=0, DEPTH=0
  logic [71:0] b_data_in;
  logic [1:0]  b_sel;
  logic        b_in_valid;
  logic [17:0] b_data_out;
  logic        b_out_valid, b_sel_err;

  pipe_mux #(.WIDTH(18), .NUM_INPUTS(4), .SELREG(0), .DEPTH(0)) u_dut_b (
    .CLK      (clk),
    .RST_N    (rst_n),
    .CE       (1'b1),
    .data_in  (b_data_in),
    .sel      (b_sel),
    .sel_ce   (1'b0),
    .in_valid (b_in_valid),
    .err_clr  (1'b0),
    .data_out (b_data_out),
    .out_valid(b_out_valid),
    .sel_err  (b_sel_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] b_exp;

  initial begin
    rst_n      = 1'b0;
    a_ce       = 1'b1;
    a_sel_ce   = 1'b0;
    a_in_valid = 1'b0;
    a_err_clr  = 1'b0;
    a_sel      = 2'd0;
    a_data_in  = {8'h33, 8'h22, 8'h11};
    b_data_in  = '0;
    b_sel      = 2'd0;
    b_in_valid = 1'b0;

    // 1. Reset held for three cycles
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("rst_data", a_data_out, 8'h00);
      chk("rst_valid", a_out_valid, 1'b0);
      chk("rst_err", a_sel_err, 1'b0);
    end
    rst_n = 1'b1;

    // 2. Selection and latency: sel=2 sampled at edge 0, valid data from edge 1
    a_sel = 2'd2; a_sel_ce = 1'b1;
    tick();                                   // edge 0
    a_sel_ce = 1'b0;
    tick();                                   // edge 1
    a_in_valid = 1'b1;
    tick();                                   // edge 2
    chk("lat_early_valid", a_out_valid, 1'b0);
    tick();                                   // edge 3
    chk("lat_data_sel2", a_data_out, 8'h33);
    chk("lat_valid_sel2", a_out_valid, 1'b1);
    a_sel = 2'd0; a_sel_ce = 1'b1;
    tick();                                   // edge 4: sel_q <= 0
    a_sel_ce = 1'b0;
    tick();                                   // edge 5
    chk("sel0_not_yet", a_data_out, 8'h33);
    tick();                                   // edge 6
    chk("sel0_data", a_data_out, 8'h11);
    chk("sel0_valid", a_out_valid, 1'b1);

    // 3. Stall mid-stream on input 0
    a_data_in = {8'h33, 8'h22, 8'h01};
    tick();
    a_data_in = {8'h33, 8'h22, 8'h02};
    tick();
    chk("stream_w1", a_data_out, 8'h01);
    a_data_in = {8'h33, 8'h22, 8'h03};
    tick();
    chk("stream_w2", a_data_out, 8'h02);
    a_ce = 1'b0;
    a_data_in = {8'h33, 8'h22, 8'h04};
    a_in_valid = 1'b0;
    tick();
    chk("stall1_data", a_data_out, 8'h02);
    chk("stall1_valid", a_out_valid, 1'b1);
    tick();
    chk("stall2_data", a_data_out, 8'h02);
    chk("stall2_valid", a_out_valid, 1'b1);
    a_ce = 1'b1;
    tick();
    chk("resume_w3", a_data_out, 8'h03);
    chk("resume_w3_valid", a_out_valid, 1'b1);
    tick();
    chk("resume_bubble_valid", a_out_valid, 1'b0);

    // 4. Out-of-range select
    a_data_in = {8'h33, 8'h22, 8'h11};
    a_sel = 2'd3; a_sel_ce = 1'b1;
    tick();                                   // A: sel_q <= 3
    tick();                                   // B: in_valid=0, no error
    chk("oor_novalid_err", a_sel_err, 1'b0);
    a_in_valid = 1'b1;
    tick();                                   // C
    chk("oor_err_set", a_sel_err, 1'b1);
    chk("oor_pre_valid", a_out_valid, 1'b0);
    tick();                                   // D
    chk("oor_data_zero", a_data_out, 8'h00);
    chk("oor_valid", a_out_valid, 1'b1);
    a_err_clr = 1'b1;
    tick();
    chk("set_wins", a_sel_err, 1'b1);
    a_err_clr = 1'b0;
    a_sel = 2'd1;
    tick();                                   // sel_q <= 1, old sel_q=3 still sets
    tick();
    chk("err_sticky", a_sel_err, 1'b1);
    a_ce = 1'b0; a_err_clr = 1'b1;
    tick();
    chk("clr_with_ce_low", a_sel_err, 1'b0);
    a_ce = 1'b1; a_err_clr = 1'b0;

    // 5. Async reset mid-stream
    tick();
    tick();
    chk("pre_rst_data", a_data_out, 8'h22);
    chk("pre_rst_valid", a_out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", a_data_out, 8'h00);
    chk("async_rst_valid", a_out_valid, 1'b0);
    tick();
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_v1", a_out_valid, 1'b0);
    tick();
    chk("post_rst_v2", a_out_valid, 1'b1);
    chk("post_rst_data_sel0", a_data_out, 8'h11);

    // 6. Combinational 4-input instance with random select and data
    for (int unsigned i = 0; i < 1000; i++) begin
      b_data_in  = {$urandom, $urandom, $urandom};
      b_sel      = 2'($urandom_range(0, 3));
      b_in_valid = 1'($urandom);
      #1;
      b_exp = b_data_in[int'(b_sel)*18 +: 18];
      chk("comb_data", b_data_out, b_exp);
      chk("comb_valid", b_out_valid, b_in_valid);
      tick();
      chk("comb_err", b_sel_err, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_mux.md
Name: pipe_mux

Overview:
Parametrised N-input multiplexer with an optional registered select and a configurable output pipeline, for DSP48A1-style datapath muxes (X/Z/pre-adder operand selection). Supersedes the fixed 4-input combinational mux.
- Adds clock enable, a valid qualifier and a sticky out-of-range-select error flag.
- Sits between operand registers and the pre-adder/multiplier/post-adder stages.

Parameters:
WIDTH, 18, data width per input (1..48)
NUM_INPUTS, 4, number of data inputs (2..8)
SELREG, 1, 1 = select held in a register loaded by sel_ce; 0 = select used combinationally
DEPTH, 1, output pipeline stages (0..4); 0 = fully combinational path
SW, derived = $clog2(NUM_INPUTS), select width (localparam, not overridable)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
CE  in  1  clock enable for the select register, pipeline and error flag
data_in  in  NUM_INPUTS*WIDTH  flattened inputs; input i = data_in[i*WIDTH +: WIDTH]
sel  in  SW  input select
sel_ce  in  1  select-register load enable (ignored when SELREG=0)
in_valid  in  1  data_in qualifier
err_clr  in  1  clears sel_err
data_out  out  WIDTH  selected data after DEPTH stages
out_valid  out  1  in_valid delayed by DEPTH stages
sel_err  out  1  sticky flag: valid data was muxed with an out-of-range select

Behaviour:
- One clock (CLK); reset asynchronous, active-low (RST_N). Assertion immediately clears:
  - sel_q, every stage data and valid bit, and sel_err to 0.
  - data_out=0 and out_valid=0 asynchronously, with no clock edge required.
  - Deassertion is assumed synchronised upstream.
- Select path:
  - SELREG=1: sel_q <= sel on a CLK edge when CE && sel_ce; otherwise hold. Reset value 0.
  - SELREG=0: sel_q = sel.
- Mux: mux_out = input[sel_q] if sel_q < NUM_INPUTS, else all-zeros.
- Pipeline:
  - DEPTH register stages, each holding {data, valid}.
  - With CE=1, every stage shifts one position per cycle: stage0 <= {mux_out, in_valid}, stage k <= stage k-1.
  - Data registers load whenever CE=1, regardless of valid. data_out is don't-care while out_valid=0, but must still be deterministic.
  - With CE=0, all stages hold, including valid bits. No bubbles are inserted or removed.
  - DEPTH=0: data_out=mux_out and out_valid=in_valid, combinationally.
- Latency:
  - data_in to data_out: DEPTH cycles.
  - sel to data_out with SELREG=1: DEPTH+1 cycles. A new sel sampled at edge n steers data presented during cycle n+1.
- Error flag:
  - On a CLK edge with CE && in_valid && sel_q >= NUM_INPUTS, sel_err <= 1.
  - Else if err_clr, sel_err <= 0.
  - Set and clear in the same cycle: set wins.
  - err_clr is honoured even when CE=0.
  - sel_err is not pipelined: it is raised at mux entry, not aligned to data_out.
- An out-of-range select with in_valid=0 does not set sel_err.
- NUM_INPUTS a power of two: out-of-range is impossible, so sel_err stays 0 (tie off constant).
- Parameter legality:
  - Elaboration error if DEPTH > 4, NUM_INPUTS < 2 or NUM_INPUTS > 8.
  - Checked via generate-time $error.

Decomposition:
- Package dsp_mux_pkg:
  - PIPE_MUX_MAX_DEPTH=4 and PIPE_MUX_MAX_INPUTS=8.
  - Function sel_width(n) returning max(1, $clog2(n)).
- Sub-module pipe_reg (WIDTH parameter):
  - One {data, valid} stage with CE and async active-low reset.
  - pipe_mux instantiates DEPTH copies in a generate loop.
  - The select register reuses pipe_reg with its valid bit unused.

Test Plan:
1. Config WIDTH=8, NUM_INPUTS=3, SELREG=1, DEPTH=2. Assert RST_N=0 for 3 cycles -> data_out=0x00, out_valid=0, sel_err=0 throughout.
2. Selection and latency:
   - Stimulus: data_in={0x33,0x22,0x11}; at edge 0 sel=2, sel_ce=1, CE=1; in_valid=1 from cycle 1.
   - Required: data_out=0x33 with out_valid=1 at edge 3.
   - Then sel=0 (sel_ce=1) -> data_out=0x11 three edges later.
3. Stall: stream in_valid=1 with data 0x01,0x02,0x03, sel=0, CE=0 for 2 cycles mid-stream -> data_out/out_valid hold for exactly those 2 cycles, then resume with no lost or duplicated word.
4. Out-of-range select:
   - sel=3, in_valid=1 -> one edge later sel_err=1; data_out=0x00 with out_valid=1 after DEPTH+1 cycles.
   - err_clr=1 with sel still 3 -> sel_err stays 1 (set wins).
   - sel=1, then err_clr=1 -> sel_err=0.
5. Async reset mid-stream: with out_valid=1, pull RST_N low between clock edges -> data_out=0 and out_valid=0 immediately. After release, the first out_valid appears only after DEPTH new valid inputs.
6. Config SELREG=0, DEPTH=0, NUM_INPUTS=4, WIDTH=18: random sel/data_in for 1000 cycles -> data_out always equals input[sel] with zero latency; sel_err never set.
